// File: rtl/rv32i_mc_control_pkg.sv
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared types and encodings for the RV32I multi-cycle control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_SUB = 7'b0100000;

endpackage

`default_nettype wire

// File: rtl/rv32i_mc_control_if.sv
// ============================================================================
// Module      : rv32i_mc_control_if
// Description : IMEM/DMEM request/ready handshake between control and memories.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv32i_mc_control_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;
    logic d_rw;

    modport master (
        output imem_req,
        output dmem_req,
        output d_rw,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  d_rw,
        output imem_ready,
        output dmem_ready
    );
endinterface

`default_nettype wire

// File: rtl/rv32i_mc_control_alu_decode.sv
// ============================================================================
// Module      : rv32i_alu_decode
// Description : Combinational opcode/funct3/funct7 to ALU Operation map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_alu_decode
    import rv32i_pkg::*;
(
    input  wire logic [6:0] opcode,
    input  wire logic [2:0] funct3,
    input  wire logic [6:0] funct7,
    output logic      [3:0] operation
);

    always_comb begin
        operation = ALU_ADD;
        case (opcode)
            OP_R, OP_I: begin
                case (funct3)
                    // Only the register form can subtract; ADDI reuses funct7 bits as immediate.
                    F3_ADD:  operation = (opcode == OP_R && funct7 == F7_SUB) ? ALU_SUB : ALU_ADD;
                    F3_SLT:  operation = ALU_SLT;
                    F3_XOR:  operation = ALU_XOR;
                    F3_OR:   operation = ALU_OR;
                    F3_AND:  operation = ALU_AND;
                    default: operation = ALU_ADD;
                endcase
            end
            OP_BRANCH: operation = ALU_SUB;
            default:   operation = ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rv32i_mc_control.sv
// ============================================================================
// Module      : rv32i_mc_control
// Description : Multi-cycle RV32I control FSM with memory wait/timeout and counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_mc_control
    import rv32i_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  wire logic             CLK,
    input  wire logic             RESET,
    rv32i_mc_control_if.master    bus,
    input  wire logic [31:0]      instr,
    input  wire logic             Zero,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  PCSrc,
    output logic                  ALUSrc,
    output logic                  MemtoReg,
    output logic                  RegWrite,
    output logic      [3:0]       Operation,
    output logic                  illegal,
    output logic                  bus_err,
    output logic      [CNT_W-1:0] cycle_cnt,
    output logic      [CNT_W-1:0] instret_cnt
);

    localparam logic [7:0] c_WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t             r_state_q, w_state_d;
    logic [7:0]         r_wait_q, w_wait_d;
    logic               r_illegal_q, w_illegal_d;
    logic               r_bus_err_q, w_bus_err_d;
    logic [CNT_W-1:0]   r_cycle_q, w_cycle_d;
    logic [CNT_W-1:0]   r_instret_q, w_instret_d;
    logic               w_retire;

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic [3:0]         w_dec_op;
    logic               w_unused_instr;

    assign w_opcode       = instr[6:0];
    assign w_funct3       = instr[14:12];
    assign w_unused_instr = ^{instr[24:15], instr[11:7]};

    rv32i_alu_decode u_alu_decode (
        .opcode    (w_opcode),
        .funct3    (w_funct3),
        .funct7    (instr[31:25]),
        .operation (w_dec_op)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_wait_d     = r_wait_q;
        w_illegal_d  = r_illegal_q;
        w_bus_err_d  = r_bus_err_q;
        w_retire     = 1'b0;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.d_rw     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        PCSrc        = 1'b0;
        ALUSrc       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        Operation    = 4'b0000;

        case (r_state_q)
            ST_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_write  = 1'b1;
                    w_state_d = ST_DECODE;
                end else if (r_wait_q == c_WAIT_LAST) begin
                    w_bus_err_d = 1'b1;
                    w_state_d   = ST_HALT;
                end else begin
                    w_wait_d = r_wait_q + 8'd1;
                end
            end
            ST_DECODE: begin
                case (w_opcode)
                    OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: w_state_d = ST_EXEC;
                    default: begin
                        w_illegal_d = 1'b1;
                        w_state_d   = ST_HALT;
                    end
                endcase
            end
            ST_EXEC: begin
                Operation = w_dec_op;
                case (w_opcode)
                    OP_R: w_state_d = ST_WB;
                    OP_I: begin
                        ALUSrc    = 1'b1;
                        w_state_d = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        ALUSrc    = 1'b1;
                        w_state_d = ST_MEM;
                    end
                    OP_BRANCH: begin
                        pc_write = 1'b1;
                        case (w_funct3)
                            F3_BEQ:  PCSrc = Zero;
                            F3_BNE:  PCSrc = ~Zero;
                            default: PCSrc = 1'b0;
                        endcase
                        w_retire  = 1'b1;
                        w_state_d = ST_FETCH;
                    end
                    default: w_state_d = ST_HALT;
                endcase
            end
            ST_MEM: begin
                bus.dmem_req = 1'b1;
                bus.d_rw     = (w_opcode == OP_STORE);
                if (bus.dmem_ready) begin
                    if (w_opcode == OP_STORE) begin
                        pc_write  = 1'b1;
                        w_retire  = 1'b1;
                        w_state_d = ST_FETCH;
                    end else begin
                        w_state_d = ST_WB;
                    end
                end else if (r_wait_q == c_WAIT_LAST) begin
                    w_bus_err_d = 1'b1;
                    w_state_d   = ST_HALT;
                end else begin
                    w_wait_d = r_wait_q + 8'd1;
                end
            end
            ST_WB: begin
                RegWrite  = 1'b1;
                MemtoReg  = (w_opcode == OP_LOAD);
                pc_write  = 1'b1;
                w_retire  = 1'b1;
                w_state_d = ST_FETCH;
            end
            ST_HALT: w_state_d = ST_HALT;
            default: w_state_d = ST_FETCH;
        endcase

        // The timeout window restarts each time a new memory request phase begins.
        if (w_state_d != r_state_q && (w_state_d == ST_FETCH || w_state_d == ST_MEM)) begin
            w_wait_d = 8'd0;
        end

        // A reset cycle must never leak a write enable from the aborted instruction.
        if (RESET) begin
            bus.imem_req = 1'b0;
            bus.dmem_req = 1'b0;
            bus.d_rw     = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            PCSrc        = 1'b0;
            ALUSrc       = 1'b0;
            MemtoReg     = 1'b0;
            RegWrite     = 1'b0;
            Operation    = 4'b0000;
        end

        w_cycle_d   = r_cycle_q + CNT_W'(1);
        w_instret_d = r_instret_q + CNT_W'(w_retire);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state_q   <= ST_FETCH;
            r_wait_q    <= 8'd0;
            r_illegal_q <= 1'b0;
            r_bus_err_q <= 1'b0;
            r_cycle_q   <= '0;
            r_instret_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_wait_q    <= w_wait_d;
            r_illegal_q <= w_illegal_d;
            r_bus_err_q <= w_bus_err_d;
            r_cycle_q   <= w_cycle_d;
            r_instret_q <= w_instret_d;
        end
    end

    assign illegal     = r_illegal_q;
    assign bus_err     = r_bus_err_q;
    assign cycle_cnt   = r_cycle_q;
    assign instret_cnt = r_instret_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_mc_control.sv
// ============================================================================
// Module      : tb_rv32i_mc_control
// Description : Directed self-checking bench for the multi-cycle control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32i_mc_control;

    localparam logic [8:0] c_IMEM = 9'h100;
    localparam logic [8:0] c_DMEM = 9'h080;
    localparam logic [8:0] c_DRW  = 9'h040;
    localparam logic [8:0] c_IRW  = 9'h020;
    localparam logic [8:0] c_PCW  = 9'h010;
    localparam logic [8:0] c_PCS  = 9'h008;
    localparam logic [8:0] c_ALUS = 9'h004;
    localparam logic [8:0] c_M2R  = 9'h002;
    localparam logic [8:0] c_REGW = 9'h001;

    localparam logic [31:0] c_ADD = 32'h002081B3;
    localparam logic [31:0] c_LW  = 32'h0000A183;
    localparam logic [31:0] c_BEQ = 32'h00208463;
    localparam logic [31:0] c_SW  = 32'h0020A023;
    localparam logic [31:0] c_BAD = 32'h0000007F;

    logic        CLK;
    logic        RESET;
    logic [31:0] instr;
    logic        Zero;
    logic        ir_write, pc_write, PCSrc, ALUSrc, MemtoReg, RegWrite;
    logic [3:0]  Operation;
    logic        illegal, bus_err;
    logic [3:0]  cycle_cnt, instret_cnt;
    logic [8:0]  ctl;

    int errors = 0;
    int checks = 0;

    rv32i_mc_control_if bus ();

    rv32i_mc_control #(
        .MAX_WAIT (4),
        .CNT_W    (4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .bus         (bus),
        .instr       (instr),
        .Zero        (Zero),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .PCSrc       (PCSrc),
        .ALUSrc      (ALUSrc),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .Operation   (Operation),
        .illegal     (illegal),
        .bus_err     (bus_err),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    assign ctl = {bus.imem_req, bus.dmem_req, bus.d_rw, ir_write, pc_write,
                  PCSrc, ALUSrc, MemtoReg, RegWrite};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, apply inputs shortly after the edge, let outputs settle.
    task automatic cyc(input logic rst, input logic [31:0] ins,
                       input logic ir, input logic dr, input logic z);
        @(posedge CLK);
        #1;
        RESET           = rst;
        instr           = ins;
        bus.imem_ready  = ir;
        bus.dmem_ready  = dr;
        Zero            = z;
        #1;
    endtask

    logic [31:0] t_ins [6];
    logic [3:0]  t_op  [6];
    logic [8:0]  t_ex  [6];

    initial begin
        t_ins[0] = c_ADD;        t_op[0] = 4'b0010; t_ex[0] = 9'h000;
        t_ins[1] = 32'h402081B3; t_op[1] = 4'b0110; t_ex[1] = 9'h000;
        t_ins[2] = 32'h0010E193; t_op[2] = 4'b0001; t_ex[2] = c_ALUS;
        t_ins[3] = 32'h0020F1B3; t_op[3] = 4'b0000; t_ex[3] = 9'h000;
        t_ins[4] = 32'h0020C1B3; t_op[4] = 4'b0011; t_ex[4] = 9'h000;
        t_ins[5] = 32'h0020A1B3; t_op[5] = 4'b0111; t_ex[5] = 9'h000;

        RESET = 1'b1; instr = 32'h0; Zero = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        cyc(1, 32'h0, 0, 0, 0);
        cyc(1, 32'h0, 0, 0, 0);
        chk("rst_ctl", 32'(ctl), 32'h0);
        chk("rst_cycle", 32'(cycle_cnt), 0);
        chk("rst_instret", 32'(instret_cnt), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_bus_err", 32'(bus_err), 0);

        // ADD with ready always high (dmem_ready high too, must be ignored)
        cyc(0, c_ADD, 1, 1, 0);
        chk("add_fetch", 32'(ctl), 32'(c_IMEM | c_IRW));
        chk("add_fetch_cycle", 32'(cycle_cnt), 0);
        cyc(0, c_ADD, 1, 1, 0);
        chk("add_decode", 32'(ctl), 32'h0);
        cyc(0, c_ADD, 1, 1, 0);
        chk("add_exec", 32'(ctl), 32'h0);
        chk("add_exec_op", 32'(Operation), 32'h2);
        cyc(0, c_ADD, 1, 1, 0);
        chk("add_wb", 32'(ctl), 32'(c_REGW | c_PCW));
        chk("add_wb_instret", 32'(instret_cnt), 0);

        // LW, DMEM ready on the 4th MEM cycle (last accepted wait cycle for MAX_WAIT=4)
        cyc(0, c_LW, 1, 0, 0);
        chk("add_retired", 32'(instret_cnt), 1);
        chk("lw_fetch_cycle", 32'(cycle_cnt), 4);
        chk("lw_fetch", 32'(ctl), 32'(c_IMEM | c_IRW));
        cyc(0, c_LW, 1, 0, 0);
        chk("lw_decode", 32'(ctl), 32'h0);
        cyc(0, c_LW, 1, 0, 0);
        chk("lw_exec", 32'(ctl), 32'(c_ALUS));
        chk("lw_exec_op", 32'(Operation), 32'h2);
        for (int i = 0; i < 4; i++) begin
            cyc(0, c_LW, 1, (i == 3), 0);
            chk("lw_mem", 32'(ctl), 32'(c_DMEM));
        end
        cyc(0, c_LW, 1, 0, 0);
        chk("lw_wb", 32'(ctl), 32'(c_REGW | c_M2R | c_PCW));
        chk("lw_no_bus_err", 32'(bus_err), 0);

        // BEQ taken, then not taken
        cyc(0, c_BEQ, 1, 0, 1);
        chk("lw_retired", 32'(instret_cnt), 2);
        chk("beq1_fetch_cycle", 32'(cycle_cnt), 12);
        chk("beq1_fetch", 32'(ctl), 32'(c_IMEM | c_IRW));
        cyc(0, c_BEQ, 1, 0, 1);
        cyc(0, c_BEQ, 1, 0, 1);
        chk("beq1_exec", 32'(ctl), 32'(c_PCW | c_PCS));
        chk("beq1_exec_op", 32'(Operation), 32'h6);
        cyc(0, c_BEQ, 1, 0, 0);
        chk("beq1_retired", 32'(instret_cnt), 3);
        cyc(0, c_BEQ, 1, 0, 0);
        cyc(0, c_BEQ, 1, 0, 0);
        chk("beq0_exec", 32'(ctl), 32'(c_PCW));

        // SW with one IMEM wait and one DMEM wait
        cyc(0, c_SW, 0, 0, 0);
        chk("beq0_retired", 32'(instret_cnt), 4);
        chk("sw_cycle_wrap", 32'(cycle_cnt), 2);
        chk("sw_fetch_wait", 32'(ctl), 32'(c_IMEM));
        cyc(0, c_SW, 1, 0, 0);
        chk("sw_fetch", 32'(ctl), 32'(c_IMEM | c_IRW));
        cyc(0, c_SW, 1, 0, 0);
        cyc(0, c_SW, 1, 0, 0);
        chk("sw_exec", 32'(ctl), 32'(c_ALUS));
        cyc(0, c_SW, 1, 0, 0);
        chk("sw_mem_wait", 32'(ctl), 32'(c_DMEM | c_DRW));
        cyc(0, c_SW, 1, 1, 0);
        chk("sw_mem_done", 32'(ctl), 32'(c_DMEM | c_DRW | c_PCW));

        // Illegal opcode
        cyc(0, c_BAD, 1, 0, 0);
        chk("sw_retired", 32'(instret_cnt), 5);
        chk("bad_fetch", 32'(ctl), 32'(c_IMEM | c_IRW));
        cyc(0, c_BAD, 1, 1, 0);
        chk("bad_decode", 32'(ctl), 32'h0);
        chk("bad_decode_flag", 32'(illegal), 0);
        cyc(0, c_BAD, 1, 1, 0);
        chk("halt_ctl", 32'(ctl), 32'h0);
        chk("halt_illegal", 32'(illegal), 1);
        cyc(0, c_BAD, 1, 1, 0);
        chk("halt_cycle", 32'(cycle_cnt), 11);
        chk("halt_instret", 32'(instret_cnt), 5);
        chk("halt_ctl2", 32'(ctl), 32'h0);

        // RESET, then IMEM stuck low
        cyc(1, c_ADD, 0, 0, 0);
        chk("rst2_ctl", 32'(ctl), 32'h0);
        cyc(0, c_ADD, 0, 0, 0);
        chk("rst2_illegal", 32'(illegal), 0);
        chk("rst2_cycle", 32'(cycle_cnt), 0);
        chk("stuck_fetch0", 32'(ctl), 32'(c_IMEM));
        cyc(0, c_ADD, 0, 0, 0);
        cyc(0, c_ADD, 0, 0, 0);
        cyc(0, c_ADD, 0, 0, 0);
        chk("stuck_fetch3", 32'(ctl), 32'(c_IMEM));
        chk("stuck_no_err_yet", 32'(bus_err), 0);
        cyc(0, c_ADD, 1, 0, 0);
        chk("timeout_ctl", 32'(ctl), 32'h0);
        chk("timeout_bus_err", 32'(bus_err), 1);
        chk("timeout_cycle", 32'(cycle_cnt), 4);
        cyc(0, c_ADD, 1, 0, 0);
        chk("timeout_cycle2", 32'(cycle_cnt), 5);
        chk("timeout_instret", 32'(instret_cnt), 0);

        // RESET clears bus_err; then abort an ADD with RESET during WB
        cyc(1, c_ADD, 1, 1, 0);
        cyc(0, c_ADD, 1, 1, 0);
        chk("rst3_bus_err", 32'(bus_err), 0);
        chk("rst3_fetch", 32'(ctl), 32'(c_IMEM | c_IRW));
        cyc(0, c_ADD, 1, 1, 0);
        cyc(0, c_ADD, 1, 1, 0);
        cyc(1, c_ADD, 1, 1, 0);
        chk("abort_wb_ctl", 32'(ctl), 32'h0);

        // Back-to-back R/I ALU ops with 4-bit counters
        cyc(0, t_ins[0], 1, 0, 0);
        for (int k = 0; k < 16; k++) begin
            chk("wrap_instret", 32'(instret_cnt), 32'(k % 16));
            chk("wrap_cycle", 32'(cycle_cnt), 32'((4 * k) % 16));
            chk("wrap_fetch", 32'(ctl), 32'(c_IMEM | c_IRW));
            cyc(0, t_ins[k % 6], 1, 0, 0);
            cyc(0, t_ins[k % 6], 1, 0, 0);
            chk("wrap_exec", 32'(ctl), 32'(t_ex[k % 6]));
            chk("wrap_exec_op", 32'(Operation), 32'(t_op[k % 6]));
            cyc(0, t_ins[k % 6], 1, 0, 0);
            chk("wrap_wb", 32'(ctl), 32'(c_REGW | c_PCW));
            cyc(0, t_ins[(k + 1) % 6], 1, 0, 0);
        end
        chk("wrap_instret_final", 32'(instret_cnt), 0);
        chk("wrap_cycle_final", 32'(cycle_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
